rv_echo_checker: RTL

// Downstream consumer of the RISC-V UART echo SoC's TX line in rv_echo simulations.
// The terminal/stimulus side pushes each byte it sends into an expected-byte FIFO.

---
 rtl/rv_echo_checker.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/rv_echo_checker.sv
// UART 8N1 receiver that checks each received byte, in order, against a FIFO of expected bytes
// and keeps match/error counters plus sticky error flags.
module rv_echo_checker #(
    parameter int unsigned CLOCK_FREQ = 1_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       exp_valid,
    input  logic [7:0]                 exp_data,
    output logic                       exp_ready,
    input  logic                       urx,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic                       byte_valid,
    output logic [7:0]                 last_got,
    output logic [7:0]                 last_exp,
    output logic [31:0]                match_cnt,
    output logic [31:0]                err_cnt,
    output logic                       mismatch,
    output logic                       unexp_err,
    output logic                       frame_err
);

    localparam int unsigned Cpb  = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned CntW = $clog2(Cpb);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned PendW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(Cpb / 2 - 1);
    localparam logic [CntW-1:0] FullLast = CntW'(Cpb - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHi} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            sync1_q, sync2_q;
    logic            line;
    logic            done;
    logic            bad_stop;

    logic [7:0]       mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PendW-1:0] pending_q;
    logic             push, pop;
    logic [7:0]       head;

    logic        byte_valid_q;
    logic [7:0]  last_got_q, last_exp_q;
    logic [31:0] match_q, err_q;
    logic        mismatch_q, unexp_q, frame_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= urx;
            sync2_q <= sync1_q;
        end
    end

    assign line = sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        done     = 1'b0;
        bad_stop = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!line) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    // A start bit that is high again at mid-bit is treated as a glitch.
                    if (line) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                        cnt_d   = '0;
                        bit_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (cnt_q == FullLast) begin
                    shift_d = {line, shift_q[7:1]};
                    cnt_d   = '0;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (cnt_q == FullLast) begin
                    if (line) begin
                        done    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        bad_stop = 1'b1;
                        state_d  = StWaitHi;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitHi: begin
                if (line) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pop decision uses the pre-edge occupancy, so a same-cycle push is not visible.
    assign push = exp_valid && exp_ready;
    assign pop  = done && (pending_q != '0);
    assign head = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= exp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pending_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                pending_q <= pending_q + PendW'(1);
            end else if (pop && !push) begin
                pending_q <= pending_q - PendW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_valid_q <= 1'b0;
            last_got_q   <= '0;
            last_exp_q   <= '0;
            match_q      <= '0;
            err_q        <= '0;
            mismatch_q   <= 1'b0;
            unexp_q      <= 1'b0;
            frame_q      <= 1'b0;
        end else begin
            byte_valid_q <= done;
            if (done) begin
                last_got_q <= shift_q;
                if (pending_q == '0) begin
                    unexp_q    <= 1'b1;
                    err_q      <= sat_inc(err_q);
                    last_exp_q <= '0;
                end else begin
                    last_exp_q <= head;
                    if (head == shift_q) begin
                        match_q <= sat_inc(match_q);
                    end else begin
                        mismatch_q <= 1'b1;
                        err_q      <= sat_inc(err_q);
                    end
                end
            end
            if (bad_stop) begin
                frame_q <= 1'b1;
                err_q   <= sat_inc(err_q);
            end
        end
    end

    assign exp_ready  = (pending_q != PendW'(DEPTH));
    assign pending    = pending_q;
    assign byte_valid = byte_valid_q;
    assign last_got   = last_got_q;
    assign last_exp   = last_exp_q;
    assign match_cnt  = match_q;
    assign err_cnt    = err_q;
    assign mismatch   = mismatch_q;
    assign unexp_err  = unexp_q;
    assign frame_err  = frame_q;

endmodule
